rxdata_fifo_rd_ctrl: RTL



---
 rtl/rxdata_fifo_rd_ctrl.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/rxdata_fifo_rd_ctrl.sv
// Receive-side FIFO read controller: pops a frame descriptor, then drains that
// frame's data words into a 2-entry AXI-Stream output buffer or discards them.
module rxdata_fifo_rd_ctrl #(
  parameter int WIDTH = 64,
  parameter int PTR   = 8,
  parameter int LENW  = 16
) (
  input  logic                 rdclk,
  input  logic                 rst,
  output logic                 rden,
  input  logic [WIDTH-1:0]     dataout,
  input  logic                 rdempty,
  input  logic [PTR:0]         rdusedw,
  output logic                 ctl_rden,
  input  logic [LENW:0]        ctl_dout,
  input  logic                 ctl_empty,
  input  logic                 drop_bad,
  output logic [WIDTH-1:0]     m_axis_tdata,
  output logic [WIDTH/8-1:0]   m_axis_tkeep,
  output logic                 m_axis_tlast,
  output logic                 m_axis_tuser,
  output logic                 m_axis_tvalid,
  input  logic                 m_axis_tready,
  output logic [31:0]          pkt_cnt,
  output logic [15:0]          drop_cnt,
  output logic                 busy
);

  localparam int KW = WIDTH / 8;
  localparam int WW = LENW - 2;
  localparam logic [WW-1:0] WONE = {{(WW-1){1'b0}}, 1'b1};
  localparam logic [WW-1:0] WZERO = {WW{1'b0}};

  typedef enum logic [1:0] {IDLE, DESC, STREAM, DROP} state_t;

  state_t            state_q;
  logic [LENW-1:0]   len_q;
  logic              bad_q;
  logic [WW-1:0]     rd_left_q;
  logic [WW-1:0]     tx_left_q;
  logic              inflight_q;
  logic [WIDTH-1:0]  buf_q [2];
  logic              head_q;
  logic [1:0]        occ_q;
  logic [31:0]       pkt_cnt_q;
  logic [15:0]       drop_cnt_q;

  logic [LENW:0]     sum_s;
  logic [WW-1:0]     words_s;
  logic              tvalid_s;
  logic              retire_s;
  logic [2:0]        pend_s;
  logic              room_s;
  logic              stream_rd_s;
  logic              drop_rd_s;
  logic              unused_rdusedw_s;

  function automatic logic [KW-1:0] last_keep(input logic [2:0] r);
    logic [KW-1:0] k;
    for (int i = 0; i < KW; i++) begin
      k[i] = (r == 3'd0) || (i < int'(r));
    end
    return k;
  endfunction

  assign unused_rdusedw_s = ^rdusedw;

  assign sum_s   = {1'b0, ctl_dout[LENW-1:0]} + {{(LENW-2){1'b0}}, 3'd7};
  assign words_s = sum_s[LENW:3];

  assign tvalid_s = (occ_q != 2'd0);
  assign retire_s = tvalid_s && m_axis_tready && (state_q == STREAM);

  // A beat retiring this cycle frees its slot, keeping 1 beat/cycle sustained.
  assign pend_s      = {1'b0, occ_q} + {2'b00, inflight_q} - {2'b00, retire_s};
  assign room_s      = (pend_s < 3'd2);
  assign stream_rd_s = (state_q == STREAM) && !rdempty && (rd_left_q != WZERO) && room_s;
  assign drop_rd_s   = (state_q == DROP) && !rdempty && (rd_left_q != WZERO);

  assign rden     = stream_rd_s || drop_rd_s;
  assign ctl_rden = (state_q == IDLE) && !ctl_empty;

  assign m_axis_tvalid = tvalid_s;
  assign m_axis_tdata  = buf_q[head_q];
  assign m_axis_tlast  = tvalid_s && (tx_left_q == WONE);
  assign m_axis_tuser  = bad_q && (state_q == STREAM);
  assign m_axis_tkeep  = !tvalid_s ? {KW{1'b0}} :
                         (tx_left_q == WONE) ? last_keep(len_q[2:0]) : {KW{1'b1}};

  assign pkt_cnt  = pkt_cnt_q;
  assign drop_cnt = drop_cnt_q;
  assign busy     = (state_q != IDLE);

  always_ff @(posedge rdclk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      len_q      <= {LENW{1'b0}};
      bad_q      <= 1'b0;
      rd_left_q  <= WZERO;
      tx_left_q  <= WZERO;
      inflight_q <= 1'b0;
      buf_q[0]   <= {WIDTH{1'b0}};
      buf_q[1]   <= {WIDTH{1'b0}};
      head_q     <= 1'b0;
      occ_q      <= 2'd0;
      pkt_cnt_q  <= 32'd0;
      drop_cnt_q <= 16'd0;
    end else begin
      inflight_q <= rden;
      case (state_q)
        IDLE: begin
          if (!ctl_empty) begin
            state_q <= DESC;
          end else begin
            state_q <= IDLE;
          end
        end
        DESC: begin
          len_q     <= ctl_dout[LENW-1:0];
          bad_q     <= ctl_dout[LENW];
          rd_left_q <= words_s;
          tx_left_q <= words_s;
          if (ctl_dout[LENW-1:0] == {LENW{1'b0}}) begin
            if (drop_cnt_q != 16'hFFFF) begin
              drop_cnt_q <= drop_cnt_q + 16'd1;
            end else begin
              drop_cnt_q <= drop_cnt_q;
            end
            state_q <= IDLE;
          end else if (ctl_dout[LENW] && drop_bad) begin
            state_q <= DROP;
          end else begin
            state_q <= STREAM;
          end
        end
        STREAM: begin
          if (rden) begin
            rd_left_q <= rd_left_q - WONE;
          end
          // Write lands behind any resident beat; head advances on retire.
          if (inflight_q) begin
            buf_q[head_q ^ occ_q[0]] <= dataout;
          end
          if (retire_s) begin
            head_q    <= ~head_q;
            tx_left_q <= tx_left_q - WONE;
          end
          occ_q <= occ_q + {1'b0, inflight_q} - {1'b0, retire_s};
          if (retire_s && (tx_left_q == WONE)) begin
            pkt_cnt_q <= pkt_cnt_q + 32'd1;
            state_q   <= IDLE;
          end else begin
            state_q <= STREAM;
          end
        end
        DROP: begin
          if (rden) begin
            rd_left_q <= rd_left_q - WONE;
          end
          if ((rd_left_q == WZERO) && !inflight_q) begin
            if (drop_cnt_q != 16'hFFFF) begin
              drop_cnt_q <= drop_cnt_q + 16'd1;
            end else begin
              drop_cnt_q <= drop_cnt_q;
            end
            state_q <= IDLE;
          end else begin
            state_q <= DROP;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule
